// File: rtl/pong_arena.sv
// pong_arena: paddle/ball object engine for a pong game.
// Keeps both paddle positions, the ball position and velocity and a
// SERVE/PLAY/SCORE state machine. All game state advances once per video frame.
// It also draws the objects at the current scan coordinate.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   btn_right  right paddle buttons, [0]=up, [1]=down
//   btn_left   left paddle buttons, [0]=up, [1]=down
//   gra_still  hold the game in SERVE with the ball centred
//   video_on   visible-area flag from the sync generator
//   x, y       current scan column / row
//   graph_on   an object is drawn at (x,y)
//   hit        1-cycle pulse when the ball bounces off a paddle
//   miss       1-cycle pulse when the ball leaves the left or right edge
//   miss_side  side of the last miss, 0=left, 1=right
//   graph_rgb  pixel colour for (x,y)
module pong_arena #(
  parameter int          CW           = 10,
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          PAD_W        = 4,
  parameter int          PAD_H        = 72,
  parameter int          PAD_STEP     = 4,
  parameter int          L_X          = 32,
  parameter int          R_X          = 600,
  parameter int          BALL_SZ      = 8,
  parameter int          V_INIT       = 2,
  parameter int          V_MAX        = 6,
  parameter int          HITS_PER_UP  = 4,
  parameter int          SERVE_FRAMES = 60,
  parameter logic [11:0] BALL_RGB     = 12'hF00,
  parameter logic [11:0] PAD_RGB      = 12'h0F0,
  parameter logic [11:0] BG_RGB       = 12'h000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    btn_right,
  input  logic [1:0]    btn_left,
  input  logic          gra_still,
  input  logic          video_on,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  output logic          graph_on,
  output logic          hit,
  output logic          miss,
  output logic          miss_side,
  output logic [11:0]   graph_rgb
);

  localparam int SW = $clog2(SERVE_FRAMES + 1);

  localparam logic [CW-1:0] PAD_TOP_MAX  = CW'(V_RES - PAD_H);
  localparam logic [CW-1:0] PAD_TOP_INIT = CW'((V_RES - PAD_H) / 2);
  localparam logic [CW-1:0] BALL_X_INIT  = CW'((H_RES - BALL_SZ) / 2);
  localparam logic [CW-1:0] BALL_Y_INIT  = CW'((V_RES - BALL_SZ) / 2);
  localparam logic [CW-1:0] BALL_Y_MAX   = CW'(V_RES - BALL_SZ);
  localparam logic [CW-1:0] X_LAST       = CW'(H_RES - 1);
  localparam logic [CW-1:0] K_VRES       = CW'(V_RES);
  localparam logic [CW-1:0] K_STEP       = CW'(PAD_STEP);
  localparam logic [CW-1:0] K_PAD_W      = CW'(PAD_W);
  localparam logic [CW-1:0] K_PAD_H      = CW'(PAD_H);
  localparam logic [CW-1:0] K_LX         = CW'(L_X);
  localparam logic [CW-1:0] K_RX         = CW'(R_X);
  localparam logic [CW-1:0] K_BALL       = CW'(BALL_SZ);
  localparam logic [CW-1:0] K_VINIT      = CW'(V_INIT);
  localparam logic [CW-1:0] K_VMAX       = CW'(V_MAX);
  localparam logic [CW-1:0] HIT_LAST     = CW'(HITS_PER_UP - 1);
  localparam logic [SW-1:0] SERVE_LAST   = SW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {SERVE, PLAY, SCORE} state_t;

  state_t        state;
  logic [CW-1:0] pad_l, pad_r, ball_x, ball_y, speed, hit_cnt;
  logic [SW-1:0] serve_cnt;
  logic          dx, dy;          // dx: 1=right, dy: 1=down
  logic          refr, refr_q, tick;

  logic [CW-1:0] y_next;
  logic          dy_next, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;
  logic          ball_on, pad_on;

  assign refr = (x == '0) && (y == K_VRES);
  assign tick = refr & ~refr_q;

  // Clamped paddle move; both or neither button means hold.
  function automatic logic [CW-1:0] pad_next(input logic [CW-1:0] top, input logic [1:0] btn);
    logic [CW-1:0] r;
    case (btn)
      2'b01:   r = (top < K_STEP) ? '0 : top - K_STEP;
      2'b10:   r = (top + K_STEP > PAD_TOP_MAX) ? PAD_TOP_MAX : top + K_STEP;
      default: r = top;
    endcase
    return r;
  endfunction

  // Next ball motion for PLAY. Comparisons are arranged so nothing underflows:
  // the left-side tests add speed on the right-hand side instead of
  // subtracting it from ball_x.
  always_comb begin
    y_next  = ball_y;
    dy_next = dy;
    if (!dy) begin
      if (ball_y < speed) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next  = ball_y - speed;
      end
    end else if (ball_y + speed > BALL_Y_MAX) begin
      y_next  = BALL_Y_MAX;
      dy_next = 1'b0;
    end else begin
      y_next  = ball_y + speed;
    end

    ov_r   = (ball_y + K_BALL > pad_r) && (ball_y < pad_r + K_PAD_H);
    ov_l   = (ball_y + K_BALL > pad_l) && (ball_y < pad_l + K_PAD_H);
    hit_r  = dx && (ball_x + K_BALL + speed >= K_RX) && (ball_x < K_RX + K_PAD_W) && ov_r;
    hit_l  = !dx && (ball_x <= K_LX + K_PAD_W + speed) && (ball_x + K_BALL > K_LX) && ov_l;
    miss_r = dx && !hit_r && (ball_x + K_BALL + speed > X_LAST);
    miss_l = !dx && !hit_l && (ball_x < speed);
  end

  // Game state: everything except the pulse clears and the edge detector
  // only moves on the per-frame tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refr_q    <= 1'b0;
      pad_l     <= PAD_TOP_INIT;
      pad_r     <= PAD_TOP_INIT;
      ball_x    <= BALL_X_INIT;
      ball_y    <= BALL_Y_INIT;
      speed     <= K_VINIT;
      dx        <= 1'b1;
      dy        <= 1'b1;
      hit_cnt   <= '0;
      serve_cnt <= '0;
      state     <= SERVE;
      hit       <= 1'b0;
      miss      <= 1'b0;
      miss_side <= 1'b0;
    end else begin
      refr_q <= refr;
      hit    <= 1'b0;
      miss   <= 1'b0;
      if (tick) begin
        pad_l <= pad_next(pad_l, btn_left);
        pad_r <= pad_next(pad_r, btn_right);
        case (state)
          SERVE: begin
            ball_x <= BALL_X_INIT;
            ball_y <= BALL_Y_INIT;
            if (gra_still) begin
              serve_cnt <= '0;
            end else if (serve_cnt == SERVE_LAST) begin
              serve_cnt <= '0;
              state     <= PLAY;
            end else begin
              serve_cnt <= serve_cnt + 1'b1;
            end
          end
          PLAY: begin
            if (gra_still) begin
              ball_x    <= BALL_X_INIT;
              ball_y    <= BALL_Y_INIT;
              serve_cnt <= '0;
              state     <= SERVE;
            end else begin
              ball_y <= y_next;
              dy     <= dy_next;
              if (hit_r || hit_l) begin
                ball_x <= hit_r ? K_RX - K_BALL : K_LX + K_PAD_W;
                dx     <= hit_l;
                hit    <= 1'b1;
                if (hit_cnt == HIT_LAST) begin
                  hit_cnt <= '0;
                  if (speed < K_VMAX) speed <= speed + 1'b1;
                end else begin
                  hit_cnt <= hit_cnt + 1'b1;
                end
              end else if (miss_r || miss_l) begin
                miss      <= 1'b1;
                miss_side <= miss_r;
                state     <= SCORE;
              end else begin
                ball_x <= dx ? ball_x + speed : ball_x - speed;
              end
            end
          end
          default: begin
            // SCORE, or a held SCORE when gra_still keeps speed/hit count.
            ball_x    <= BALL_X_INIT;
            ball_y    <= BALL_Y_INIT;
            serve_cnt <= '0;
            state     <= SERVE;
            if (!gra_still) begin
              speed   <= K_VINIT;
              hit_cnt <= '0;
              dx      <= miss_side;
            end
          end
        endcase
      end
    end
  end

  // Object rendering; the ball wins over a paddle on the same pixel.
  always_comb begin
    ball_on = (x >= ball_x) && (x < ball_x + K_BALL) &&
              (y >= ball_y) && (y < ball_y + K_BALL);
    pad_on  = ((x >= K_LX) && (x < K_LX + K_PAD_W) && (y >= pad_l) && (y < pad_l + K_PAD_H)) ||
              ((x >= K_RX) && (x < K_RX + K_PAD_W) && (y >= pad_r) && (y < pad_r + K_PAD_H));
    graph_on = video_on & (ball_on | pad_on);
    if (!video_on)    graph_rgb = 12'h000;
    else if (ball_on) graph_rgb = BALL_RGB;
    else if (pad_on)  graph_rgb = PAD_RGB;
    else              graph_rgb = BG_RGB;
  end

endmodule

// File: tb/tb_pong_arena.sv
// tb_pong_arena: self-checking bench for pong_arena. Frames are produced by
// pulsing the scan coordinate to the refresh point instead of sweeping the
// whole raster. A frame-level game model in plain integer arithmetic predicts
// the outputs and the paddle/ball state.
module tb_pong_arena;

  localparam int CW = 10, H_RES = 640, V_RES = 480, PAD_W = 4, PAD_H = 72;
  localparam int PAD_STEP = 4, L_X = 32, R_X = 600, BALL_SZ = 8;
  localparam int V_INIT = 2, V_MAX = 6, HITS_PER_UP = 4, SERVE_FRAMES = 60;
  localparam int BALL_RGB = 'hF00, PAD_RGB = 'h0F0, BG_RGB = 'h000;
  localparam int BX0 = (H_RES - BALL_SZ) / 2, BY0 = (V_RES - BALL_SZ) / 2;
  localparam int PT0 = (V_RES - PAD_H) / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    btn_right = 2'b00, btn_left = 2'b00;
  logic          gra_still = 1'b0, video_on = 1'b1;
  logic [CW-1:0] x = '0, y = '0;
  logic          graph_on, hit, miss, miss_side;
  logic [11:0]   graph_rgb;

  always #5 clk = ~clk;

  pong_arena #(
    .CW(CW), .H_RES(H_RES), .V_RES(V_RES), .PAD_W(PAD_W), .PAD_H(PAD_H),
    .PAD_STEP(PAD_STEP), .L_X(L_X), .R_X(R_X), .BALL_SZ(BALL_SZ),
    .V_INIT(V_INIT), .V_MAX(V_MAX), .HITS_PER_UP(HITS_PER_UP),
    .SERVE_FRAMES(SERVE_FRAMES), .BALL_RGB(12'hF00), .PAD_RGB(12'h0F0), .BG_RGB(12'h000)
  ) dut (
    .clk(clk), .reset(reset), .btn_right(btn_right), .btn_left(btn_left),
    .gra_still(gra_still), .video_on(video_on), .x(x), .y(y),
    .graph_on(graph_on), .hit(hit), .miss(miss), .miss_side(miss_side),
    .graph_rgb(graph_rgb)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Game model: phase 0=serving, 1=playing, 2=scored. Velocity as signed unit.
  int m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_spd, m_hits, m_serve, m_ph;
  bit m_hit, m_miss, m_side;

  typedef struct {
    int px;
    int py;
    bit vid;
    bit on;
    int rgb;
  } rvec_t;
  rvec_t rtab[17];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fails++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int pad_delta(input logic [1:0] b);
    return (b == 2'b01) ? -PAD_STEP : (b == 2'b10) ? PAD_STEP : 0;
  endfunction

  task automatic model_reset();
    m_pl = PT0; m_pr = PT0; m_bx = BX0; m_by = BY0;
    m_vx = 1; m_vy = 1; m_spd = V_INIT; m_hits = 0; m_serve = 0; m_ph = 0;
    m_hit = 0; m_miss = 0; m_side = 0;
  endtask

  task automatic model_step(input logic [1:0] bl, input logic [1:0] br, input logic still);
    int  nx, ny, v0;
    bit  ov_r, ov_l, hr, hl;
    m_hit = 0; m_miss = 0;
    if (m_ph == 0) begin
      m_bx = BX0; m_by = BY0;
      if (still) m_serve = 0;
      else if (m_serve == SERVE_FRAMES - 1) begin m_ph = 1; m_serve = 0; end
      else m_serve++;
    end else if (still) begin
      m_bx = BX0; m_by = BY0; m_ph = 0; m_serve = 0;
    end else if (m_ph == 2) begin
      m_spd = V_INIT; m_hits = 0; m_bx = BX0; m_by = BY0;
      m_vx = m_side ? 1 : -1; m_ph = 0; m_serve = 0;
    end else begin
      ny = m_by + m_vy * m_spd;
      if (ny < 0) begin ny = 0; m_vy = 1; end
      else if (ny > V_RES - BALL_SZ) begin ny = V_RES - BALL_SZ; m_vy = -1; end
      v0 = m_vx;
      nx = m_bx + v0 * m_spd;
      ov_r = (m_by + BALL_SZ > m_pr) && (m_by < m_pr + PAD_H);
      ov_l = (m_by + BALL_SZ > m_pl) && (m_by < m_pl + PAD_H);
      hr = (v0 > 0) && (nx + BALL_SZ >= R_X) && (m_bx < R_X + PAD_W) && ov_r;
      hl = (v0 < 0) && (nx <= L_X + PAD_W) && (m_bx + BALL_SZ > L_X) && ov_l;
      if (hr || hl) begin
        nx = hr ? R_X - BALL_SZ : L_X + PAD_W;
        m_vx = hr ? -1 : 1;
        m_hit = 1;
        m_hits++;
        if (m_hits == HITS_PER_UP) begin
          m_hits = 0;
          m_spd = (m_spd + 1 > V_MAX) ? V_MAX : m_spd + 1;
        end
      end else if ((v0 > 0 && nx + BALL_SZ > H_RES - 1) || (v0 < 0 && nx < 0)) begin
        m_miss = 1; m_side = (v0 > 0); m_ph = 2; nx = m_bx;
      end
      m_bx = nx; m_by = ny;
    end
    m_pl = clampi(m_pl + pad_delta(bl), 0, V_RES - PAD_H);
    m_pr = clampi(m_pr + pad_delta(br), 0, V_RES - PAD_H);
  endtask

  function automatic int exp_rgb(input int px, input int py, input bit vid);
    bit b, p;
    b = px >= m_bx && px < m_bx + BALL_SZ && py >= m_by && py < m_by + BALL_SZ;
    p = (px >= L_X && px < L_X + PAD_W && py >= m_pl && py < m_pl + PAD_H) ||
        (px >= R_X && px < R_X + PAD_W && py >= m_pr && py < m_pr + PAD_H);
    if (!vid) return 0;
    if (b) return BALL_RGB;
    if (p) return PAD_RGB;
    return BG_RGB;
  endfunction

  function automatic bit exp_on(input int px, input int py, input bit vid);
    bit b, p;
    b = px >= m_bx && px < m_bx + BALL_SZ && py >= m_by && py < m_by + BALL_SZ;
    p = (px >= L_X && px < L_X + PAD_W && py >= m_pl && py < m_pl + PAD_H) ||
        (px >= R_X && px < R_X + PAD_W && py >= m_pr && py < m_pr + PAD_H);
    return vid && (b || p);
  endfunction

  task automatic checkState();
    checkOutput("pad_l", int'(dut.pad_l), m_pl);
    checkOutput("pad_r", int'(dut.pad_r), m_pr);
    checkOutput("ball_x", int'(dut.ball_x), m_bx);
    checkOutput("ball_y", int'(dut.ball_y), m_by);
    checkOutput("speed", int'(dut.speed), m_spd);
    checkOutput("dx", int'(dut.dx), (m_vx > 0) ? 1 : 0);
    checkOutput("miss_side", int'(miss_side), int'(m_side));
  endtask

  task automatic probe(input int px, input int py, input bit vid);
    x = CW'(px); y = CW'(py); video_on = vid;
    #1;
    checkOutput("graph_on", int'(graph_on), int'(exp_on(px, py, vid)));
    checkOutput("graph_rgb", int'(graph_rgb), exp_rgb(px, py, vid));
  endtask

  // One video frame: a refresh point produces the tick, the following
  // negedge samples the pulses and state, then a random pixel is probed.
  task automatic applyStimulus(input logic [1:0] bl, input logic [1:0] br, input logic still);
    int rx, ry;
    @(negedge clk);
    btn_left = bl; btn_right = br; gra_still = still;
    x = '0; y = CW'(V_RES);
    @(negedge clk);
    model_step(bl, br, still);
    checkOutput("hit", int'(hit), int'(m_hit));
    checkOutput("miss", int'(miss), int'(m_miss));
    checkState();
    case ($urandom_range(0, 2))
      0: begin
        rx = m_bx - 2 + int'($urandom_range(0, 11));
        ry = m_by - 2 + int'($urandom_range(0, 11));
      end
      1: begin
        rx = R_X - 1 + int'($urandom_range(0, 5));
        ry = m_pr - 2 + int'($urandom_range(0, PAD_H + 3));
      end
      default: begin
        rx = int'($urandom_range(0, H_RES - 1));
        ry = int'($urandom_range(0, V_RES - 1));
      end
    endcase
    probe(clampi(rx, 0, H_RES - 1), clampi(ry, 0, V_RES - 1), $urandom_range(0, 7) != 0);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    reset = 1'b0; x = CW'(1); y = '0;
    repeat (cycles) @(negedge clk);
    model_reset();
    checkOutput("rst_hit", int'(hit), 0);
    checkOutput("rst_miss", int'(miss), 0);
    checkState();
    reset = 1'b1;
  endtask

  // Steer a paddle so its centre follows the ball centre.
  function automatic logic [1:0] track(input int top);
    int want;
    want = m_by + BALL_SZ / 2 - PAD_H / 2;
    if (top < want - 2) return 2'b10;
    if (top > want + 2) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    int  hits_seen;
    bit  got_miss;
    int  side_dir;
    logic [1:0] bl, br;

    rtab[0]  = '{320, 240, 1'b1, 1'b1, 'hF00};
    rtab[1]  = '{0,   0,   1'b1, 1'b0, 'h000};
    rtab[2]  = '{316, 236, 1'b1, 1'b1, 'hF00};
    rtab[3]  = '{323, 243, 1'b1, 1'b1, 'hF00};
    rtab[4]  = '{324, 240, 1'b1, 1'b0, 'h000};
    rtab[5]  = '{315, 240, 1'b1, 1'b0, 'h000};
    rtab[6]  = '{320, 244, 1'b1, 1'b0, 'h000};
    rtab[7]  = '{33,  210, 1'b1, 1'b1, 'h0F0};
    rtab[8]  = '{32,  204, 1'b1, 1'b1, 'h0F0};
    rtab[9]  = '{35,  275, 1'b1, 1'b1, 'h0F0};
    rtab[10] = '{36,  240, 1'b1, 1'b0, 'h000};
    rtab[11] = '{33,  276, 1'b1, 1'b0, 'h000};
    rtab[12] = '{33,  203, 1'b1, 1'b0, 'h000};
    rtab[13] = '{601, 240, 1'b1, 1'b1, 'h0F0};
    rtab[14] = '{604, 240, 1'b1, 1'b0, 'h000};
    rtab[15] = '{320, 240, 1'b0, 1'b0, 'h000};
    rtab[16] = '{33,  240, 1'b0, 1'b0, 'h000};

    $display("[TB] reset and initial render");
    doReset(2);
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("init_pad_r", int'(dut.pad_r), 204);
    checkOutput("init_ball_x", int'(dut.ball_x), 316);
    checkOutput("init_ball_y", int'(dut.ball_y), 236);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      x = CW'(rtab[i].px); y = CW'(rtab[i].py); video_on = rtab[i].vid;
      #1;
      checkOutput($sformatf("tab%0d_on", i), int'(graph_on), int'(rtab[i].on));
      checkOutput($sformatf("tab%0d_rgb", i), int'(graph_rgb), rtab[i].rgb);
    end

    $display("[TB] paddle clamps with the game held");
    for (int f = 0; f < 60; f++) begin
      applyStimulus(2'b00, 2'b01, 1'b1);
      checkOutput("still_ball_x", int'(dut.ball_x), 316);
    end
    checkOutput("pad_r_top_clamp", int'(dut.pad_r), 0);
    for (int f = 0; f < 5; f++) applyStimulus(2'b00, 2'b11, 1'b1);
    checkOutput("pad_r_both_hold", int'(dut.pad_r), 0);
    for (int f = 0; f < 110; f++) applyStimulus(2'b00, 2'b10, 1'b1);
    checkOutput("pad_r_bottom_clamp", int'(dut.pad_r), 408);

    $display("[TB] serve delay");
    doReset(1);
    for (int f = 0; f < 60; f++) begin
      applyStimulus(2'b00, 2'b00, 1'b0);
      checkOutput("serve_hold_x", int'(dut.ball_x), 316);
    end
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("launch_x", int'(dut.ball_x), 318);
    checkOutput("launch_y", int'(dut.ball_y), 238);

    $display("[TB] paddle hits and speed-up");
    hits_seen = 0;
    for (int f = 0; f < 3000 && hits_seen < 4; f++) begin
      applyStimulus(track(m_pl), track(m_pr), 1'b0);
      if (hit) begin
        hits_seen++;
        checkOutput("hit_dx_flip", int'(dut.dx), (hits_seen % 2 == 1) ? 0 : 1);
      end
    end
    checkOutput("hits_seen", hits_seen, 4);
    checkOutput("speed_after_4_hits", int'(dut.speed), 3);

    $display("[TB] miss, score and re-serve");
    got_miss = 0;
    for (int f = 0; f < 4000 && !got_miss; f++) begin
      br = (m_by >= BY0) ? 2'b01 : 2'b10;
      applyStimulus(track(m_pl), br, 1'b0);
      if (miss) got_miss = 1;
    end
    checkOutput("miss_seen", int'(got_miss), 1);
    side_dir = m_side ? 2 : -2;
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("score_speed", int'(dut.speed), V_INIT);
    checkOutput("score_ball_x", int'(dut.ball_x), 316);
    for (int f = 0; f < 60; f++) begin
      applyStimulus(2'b00, 2'b00, 1'b0);
      checkOutput("reserve_hold_x", int'(dut.ball_x), 316);
    end
    applyStimulus(2'b00, 2'b00, 1'b0);
    checkOutput("reserve_launch_x", int'(dut.ball_x), 316 + side_dir);

    $display("[TB] reset during play");
    for (int f = 0; f < 20; f++) applyStimulus(track(m_pl), track(m_pr), 1'b0);
    doReset(1);
    checkOutput("midrst_ball_x", int'(dut.ball_x), 316);
    checkOutput("midrst_speed", int'(dut.speed), 2);

    $display("[TB] randomized play against the model");
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(0, 399) == 0) begin
        doReset(1);
      end else begin
        bl = ($urandom_range(0, 3) != 0) ? track(m_pl) : 2'($urandom_range(0, 3));
        br = ($urandom_range(0, 3) != 0) ? track(m_pr) : 2'($urandom_range(0, 3));
        applyStimulus(bl, br, $urandom_range(0, 99) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
